// File: rtl/cmd_packet_tx.sv
// -----------------------------------------------------------------------------
// cmd_packet_tx
// Host-side framer for the robot command link. On an accepted send it snapshots
// four motor bytes plus {dribbler,kick} and hands them one byte at a time to a
// UART transmitter. The byte order is HEADER, M1, M2, M3, M4, {dribbler,kick[6:0]},
// which matches what the robot-side control unit decodes.
//
// Build option:
//   PKT_CHECKSUM_EN  when defined, a seventh byte M1^M2^M3^M4^{dribbler,kick}
//                    (header excluded) is appended to every packet.
//
// Parameters:
//   HEADER       key byte sent first in every packet
//   GAP_CYCLES   idle clk cycles inserted after each byte completes (0 = back-to-back)
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   asynchronous, active-low reset
//   send          in   one-cycle request to transmit a packet
//   motor1..4     in   motor command bytes, sampled on accepted send
//   kick          in   kick strength, sampled on accepted send
//   dribbler      in   dribbler enable, sampled on accepted send
//   tx_busy       in   UART TX busy, high while a byte is shifting out
//   tx_data       out  byte for UART TX, qualified by tx_start
//   tx_start      out  one-cycle load strobe to UART TX
//   busy          out  high from accepted send until packet done
//   done          out  one-cycle pulse after the last byte completes
//   send_dropped  out  one-cycle pulse when send arrives while a packet is in flight
// -----------------------------------------------------------------------------
module cmd_packet_tx #(
    parameter logic [7:0] HEADER     = 8'hFF,
    parameter int         GAP_CYCLES = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       send,
    input  logic [7:0] motor1,
    input  logic [7:0] motor2,
    input  logic [7:0] motor3,
    input  logic [7:0] motor4,
    input  logic [6:0] kick,
    input  logic       dribbler,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       busy,
    output logic       done,
    output logic       send_dropped
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_ACK,
        S_WAIT_DONE,
        S_GAP,
        S_FINISH
    } state_t;

`ifdef PKT_CHECKSUM_EN
    localparam logic [2:0] LAST_IDX = 3'd6;
`else
    localparam logic [2:0] LAST_IDX = 3'd5;
`endif

    localparam int            GW       = (GAP_CYCLES < 2) ? 1 : $clog2(GAP_CYCLES);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYCLES - 1);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [2:0]      r_idx;
    logic [7:0]      r_m1;
    logic [7:0]      r_m2;
    logic [7:0]      r_m3;
    logic [7:0]      r_m4;
    logic [7:0]      r_kd;
    logic [7:0]      r_tx_data;
    logic            r_tx_start;
    logic [GW-1:0]   r_gap_cnt;

    logic            w_load;
    logic            w_fire;
    logic            w_idx_inc;
    logic            w_gap_clr;
    logic            w_gap_inc;
    logic [7:0]      w_byte;

    // Byte selected by the current index, taken from the snapshot only.
    always_comb begin
        w_byte = HEADER;
        case (r_idx)
            3'd0:    w_byte = HEADER;
            3'd1:    w_byte = r_m1;
            3'd2:    w_byte = r_m2;
            3'd3:    w_byte = r_m3;
            3'd4:    w_byte = r_m4;
            3'd5:    w_byte = r_kd;
`ifdef PKT_CHECKSUM_EN
            3'd6:    w_byte = r_m1 ^ r_m2 ^ r_m3 ^ r_m4 ^ r_kd;
`endif
            default: w_byte = HEADER;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus the decoded status outputs. busy drops in FINISH so the
    // host sees it fall together with done, but a send there is still refused.
    always_comb begin
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        w_fire       = 1'b0;
        w_idx_inc    = 1'b0;
        w_gap_clr    = 1'b0;
        w_gap_inc    = 1'b0;
        busy         = (r_state != S_IDLE) && (r_state != S_FINISH);
        done         = (r_state == S_FINISH);
        send_dropped = send && (r_state != S_IDLE);
        case (r_state)
            S_IDLE: begin
                if (send) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (!tx_busy) begin
                    w_fire      = 1'b1;
                    w_state_nxt = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (tx_busy) begin
                    w_state_nxt = S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (!tx_busy) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = S_FINISH;
                    end else begin
                        w_idx_inc = 1'b1;
                        if (GAP_CYCLES > 0) begin
                            w_gap_clr   = 1'b1;
                            w_state_nxt = S_GAP;
                        end else begin
                            w_state_nxt = S_START;
                        end
                    end
                end
            end
            S_GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_nxt = S_START;
                end else begin
                    w_gap_inc = 1'b1;
                end
            end
            S_FINISH: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Snapshot, byte index, gap counter and the registered TX strobe/data.
    // tx_start is registered so the first strobe lands two cycles after send.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx      <= 3'd0;
            r_m1       <= 8'h00;
            r_m2       <= 8'h00;
            r_m3       <= 8'h00;
            r_m4       <= 8'h00;
            r_kd       <= 8'h00;
            r_tx_data  <= 8'h00;
            r_tx_start <= 1'b0;
            r_gap_cnt  <= '0;
        end else begin
            r_tx_start <= w_fire;
            if (w_load) begin
                r_m1  <= motor1;
                r_m2  <= motor2;
                r_m3  <= motor3;
                r_m4  <= motor4;
                r_kd  <= {dribbler, kick};
                r_idx <= 3'd0;
            end else if (w_idx_inc) begin
                r_idx <= r_idx + 3'd1;
            end
            if (w_fire) begin
                r_tx_data <= w_byte;
            end
            if (w_gap_clr) begin
                r_gap_cnt <= '0;
            end else if (w_gap_inc) begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_start = r_tx_start;

endmodule

// File: tb/tb_cmd_packet_tx.sv
module tb_cmd_packet_tx;

    localparam int TB_GAP = 3;
`ifdef PKT_CHECKSUM_EN
    localparam int NBYTES = 7;
`else
    localparam int NBYTES = 6;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       send;
    logic [7:0] motor1, motor2, motor3, motor4;
    logic [6:0] kick;
    logic       dribbler;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       busy;
    logic       done;
    logic       send_dropped;

    always #5 clk = ~clk;

    cmd_packet_tx #(
        .HEADER    (8'hFF),
        .GAP_CYCLES(TB_GAP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .send        (send),
        .motor1      (motor1),
        .motor2      (motor2),
        .motor3      (motor3),
        .motor4      (motor4),
        .kick        (kick),
        .dribbler    (dribbler),
        .tx_busy     (tx_busy),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .busy        (busy),
        .done        (done),
        .send_dropped(send_dropped)
    );

    // UART TX model: 10 busy cycles per byte, plus an override to hold it busy.
    int   busy_cnt   = 0;
    logic force_busy = 1'b0;
    always @(posedge clk) begin
        if (tx_start && busy_cnt == 0) busy_cnt <= 10;
        else if (busy_cnt > 0)         busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = force_busy || (busy_cnt != 0);

    // Monitor on the falling edge.
    int         cyc = 0;
    logic [7:0] log_q[$];
    int         pkt_base = 0;
    int         first_start_cyc = -1;
    int         done_cnt = 0, drop_cnt = 0, dbl_cnt = 0;
    int         idle = 0, min_idle = 1000;
    logic       prev_start = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_start) begin
            if (log_q.size() == pkt_base) first_start_cyc = cyc;
            else if (idle < min_idle)     min_idle = idle;
            log_q.push_back(tx_data);
            idle = 0;
            if (prev_start) dbl_cnt++;
        end else if (!tx_busy) begin
            idle++;
        end
        if (done)         done_cnt++;
        if (send_dropped) drop_cnt++;
        prev_start = tx_start;
    end

    typedef struct {
        logic [7:0] m1, m2, m3, m4;
        logic [6:0] kick;
        logic       drib;
        logic [7:0] exp_kd;
        logic [7:0] exp_csum;
    } vec_t;

    vec_t vecs[4];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_done(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            tick();
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic start_pkt(input vec_t v, output int scyc);
        pkt_base        = log_q.size();
        min_idle        = 1000;
        first_start_cyc = -1;
        motor1   = v.m1;
        motor2   = v.m2;
        motor3   = v.m3;
        motor4   = v.m4;
        kick     = v.kick;
        dribbler = v.drib;
        send     = 1'b1;
        scyc     = cyc;
        tick();
        send     = 1'b0;
        motor1   = 8'h55;
        motor2   = 8'h55;
        motor3   = 8'h55;
        motor4   = 8'h55;
        kick     = 7'h55;
        dribbler = ~v.drib;
    endtask

    task automatic check_bytes(input vec_t v, input string tag);
        logic [7:0] exp_b[7];
        exp_b[0] = 8'hFF;
        exp_b[1] = v.m1;
        exp_b[2] = v.m2;
        exp_b[3] = v.m3;
        exp_b[4] = v.m4;
        exp_b[5] = v.exp_kd;
        exp_b[6] = v.exp_csum;
        check({tag, "_nbytes"}, log_q.size() - pkt_base, NBYTES);
        for (int b = 0; b < NBYTES; b++) begin
            if (pkt_base + b < log_q.size())
                check($sformatf("%s_byte%0d", tag, b), log_q[pkt_base + b], exp_b[b]);
            else
                check($sformatf("%s_byte%0d_missing", tag, b), 0, 1);
        end
    endtask

    task automatic run_pkt(input vec_t v, input string tag);
        int scyc;
        int d0;
        bit ok;
        d0 = done_cnt;
        start_pkt(v, scyc);
        check({tag, "_busy_after_send"}, busy, 1);
        wait_done(500, ok);
        check({tag, "_done_seen"}, ok, 1);
        check({tag, "_busy_low_at_done"}, busy, 0);
        tick();
        check({tag, "_done_pulses"}, done_cnt - d0, 1);
        check({tag, "_latency"}, first_start_cyc - scyc, 2);
        check({tag, "_gap_ok"}, min_idle >= TB_GAP, 1);
        check_bytes(v, tag);
    endtask

    initial begin
        bit ok;
        int scyc;
        int base;
        int d0;
        // M1..M4, kick, drib, {drib,kick}, xor checksum (hand computed)
        vecs[0] = '{8'h01, 8'h02, 8'h03, 8'h04, 7'h10, 1'b1, 8'h90, 8'h94};
        vecs[1] = '{8'hFF, 8'hFF, 8'h00, 8'h80, 7'h7F, 1'b0, 8'h7F, 8'hFF};
        vecs[2] = '{8'hAA, 8'h55, 8'h0F, 8'hF0, 7'h00, 1'b1, 8'h80, 8'h80};
        vecs[3] = '{8'h00, 8'h00, 8'h00, 8'h00, 7'h01, 1'b0, 8'h01, 8'h01};

        reset = 1'b0; send = 1'b0;
        motor1 = 8'h00; motor2 = 8'h00; motor3 = 8'h00; motor4 = 8'h00;
        kick = 7'h00; dribbler = 1'b0;
        tick();
        tick();
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_tx_start", tx_start, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_send_dropped", send_dropped, 0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) begin
            run_pkt(vecs[i], $sformatf("vec%0d", i));
            repeat (3) tick();
        end

        // send during byte 3, then again in the FINISH cycle
        d0 = drop_cnt;
        base = done_cnt;
        start_pkt(vecs[0], scyc);
        for (int i = 0; i < 300 && (log_q.size() - pkt_base) < 4; i++) tick();
        send = 1'b1;
        #1;
        check("drop_pulse", send_dropped, 1);
        tick();
        send = 1'b0;
        #1;
        check("drop_one_cycle", send_dropped, 0);
        wait_done(500, ok);
        check("drop_done_seen", ok, 1);
        send = 1'b1;
        #1;
        check("drop_in_finish", send_dropped, 1);
        tick();
        send = 1'b0;
        check_bytes(vecs[0], "drop");
        repeat (50) tick();
        check("drop_no_second_pkt", log_q.size() - pkt_base, NBYTES);
        check("drop_count", drop_cnt - d0, 2);
        check("drop_done_count", done_cnt - base, 1);
        check("drop_idle_busy", busy, 0);

        // reset while byte 2 is shifting out
        start_pkt(vecs[1], scyc);
        for (int i = 0; i < 300 && (log_q.size() - pkt_base) < 3; i++) tick();
        repeat (4) tick();
        check("midrst_in_wait_done", tx_busy, 1);
        reset = 1'b0;
        #1;
        check("midrst_tx_start", tx_start, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_tx_data", tx_data, 8'h00);
        tick();
        reset = 1'b1;
        base = log_q.size();
        repeat (40) tick();
        check("midrst_no_restart", log_q.size() - base, 0);
        run_pkt(vecs[2], "postrst");
        repeat (3) tick();

        // TX held busy by someone else before the send
        force_busy = 1'b1;
        start_pkt(vecs[3], scyc);
        repeat (20) tick();
        check("hold_no_start", log_q.size() - pkt_base, 0);
        check("hold_busy", busy, 1);
        force_busy = 1'b0;
        wait_done(500, ok);
        check("hold_done_seen", ok, 1);
        tick();
        check_bytes(vecs[3], "hold");

        check("strobe_single_cycle", dbl_cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
